muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer in the EX stage, beside the ALU.

---
 rtl/muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle hardware multiply for MUL*.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rD1,
  input  logic [XLEN-1:0] rD2,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] C
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  state_t            state, state_nxt;
  op_t               op_in, op_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_q;
  logic              neg_q;

  // Issue-time operand conditioning
  logic            issue, is_div, div_zero, fast_path;
  logic            signed1, signed2, s1, s2, neg_issue;
  logic [XLEN-1:0] mag1, mag2;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   quo, rem, result;
  logic              last_iter;

  always_comb begin
    op_in   = op_t'(op);
    is_div  = op[2];
    signed1 = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
              (op_in == OP_DIV)  || (op_in == OP_REM);
    signed2 = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    s1      = signed1 & rD1[XLEN-1];
    s2      = signed2 & rD2[XLEN-1];
    mag1    = s1 ? (-rD1) : rD1;
    mag2    = s2 ? (-rD2) : rD2;
    // Remainder takes the dividend's sign; everything else the xor of both.
    neg_issue = (op_in == OP_REM) ? s1 : (s1 ^ s2);
    div_zero  = is_div && (rD2 == '0);
`ifdef MULDIV_FAST_MUL_EN
    fast_path = div_zero || !is_div;
`else
    fast_path = div_zero;
`endif
    issue = (state == S_IDLE) && valid_in && !flush;
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_shift[XLEN-1:0] - b_q;
    last_iter = (cnt == CNT_W'(XLEN - 1));
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (valid_in && !flush) begin
          stall     = 1'b1;
          state_nxt = fast_path ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          stall = 1'b1;
          if (last_iter) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = !flush;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // acc doubles as {hi,lo} product or {remainder,quotient} register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_MUL;
      cnt   <= '0;
      acc   <= '0;
      b_q   <= '0;
      neg_q <= 1'b0;
    end else if (issue) begin
      op_q <= op_in;
      cnt  <= '0;
      b_q  <= mag2;
      if (div_zero) begin
        acc   <= {rD1, {XLEN{1'b1}}};
        neg_q <= 1'b0;
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        acc <= is_div ? {{XLEN{1'b0}}, mag1}
                      : ({{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2});
`else
        acc <= {{XLEN{1'b0}}, mag1};
`endif
        neg_q <= neg_issue;
      end
    end else if (state == S_CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (op_q[2]) begin
        if (div_ge) acc <= {div_rem, acc[XLEN-2:0], 1'b1};
        else        acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc <= {mul_sum, acc[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    mul_full = neg_q ? (-acc) : acc;
    quo      = neg_q ? (-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem      = neg_q ? (-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    unique case (op_q)
      OP_MUL:                        result = mul_full[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  result = mul_full[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               result = quo;
      OP_REM, OP_REMU:               result = rem;
      default:                       result = '0;
    endcase
    C = done ? result : '0;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq (default or MULDIV_FAST_MUL_EN build).
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [2:0]  op;
  logic [31:0] rD1, rD2;
  logic        flush;
  logic        stall, done;
  logic [31:0] C;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .op(op), .rD1(rD1), .rD2(rD2),
    .flush(flush), .stall(stall), .done(done), .C(C)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int expected_lat(input logic [2:0] o, input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    if (o[2] && b == 32'd0) return 1;
    return 33;
  endfunction

  // Drive an instruction in the current cycle (T0); caller is just after a rising edge.
  task automatic issue(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    valid_in = 1'b1; op = o; rD1 = a; rD2 = b;
    exp_q.push_back(exp);
    #1 check({tag, "_stall_t0"}, {31'd0, stall}, 32'd1);
  endtask

  task automatic await(input string tag, input int lat);
    int n = 0;
    logic got = 1'b0, stall_ok = 1'b1, czero_ok = 1'b1;
    logic [31:0] exp;
    while (!got && n < 80) begin
      @(posedge clk); #2;
      n++;
      if (done) got = 1'b1;
      else begin
        if (stall !== 1'b1) stall_ok = 1'b0;
        if (C !== 32'd0) czero_ok = 1'b0;
      end
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_stall_held"}, {31'd0, stall_ok}, 32'd1);
    check({tag, "_c_zero_idle"}, {31'd0, czero_ok}, 32'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    if (got) begin
      check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
      check({tag, "_C"}, C, exp);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(posedge clk); #1;
    issue(tag, o, a, b, exp);
    await(tag, expected_lat(o, b));
  endtask

  initial begin
    logic no_done;
    rst = 1'b1; valid_in = 1'b0; op = 3'b000; rD1 = '0; rD2 = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_C", C, 32'd0);
    rst = 1'b0;

    run_op("mul_7_m3",      MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulhu_max",     MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulhsu_m1_2",   MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    run_op("mulh_min_min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("div_m7_2",      DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op("rem_m7_2",      REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op("divu_100_7",    DIVU,   32'd100,       32'd7,         32'd14);
    run_op("remu_100_7",    REMU,   32'd100,       32'd7,         32'd2);
    run_op("divu_5_0",      DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
    run_op("rem_5_0",       REM,    32'd5,         32'd0,         32'd5);
    run_op("div_ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush a divide at T10, then issue a multiply at T11.
    @(posedge clk); #1;
    valid_in = 1'b1; op = DIV; rD1 = 32'd1000; rD2 = 32'd3;
    no_done = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) no_done = 1'b0;
    end
    flush = 1'b1;
    #1 check("flush_stall_t10", {31'd0, stall}, 32'd0);
    check("flush_done_t10", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    if (done !== 1'b0) no_done = 1'b0;
    check("flush_no_done", {31'd0, no_done}, 32'd1);
    issue("mul_after_flush", MUL, 32'd123, 32'd456, 32'd56088);
    await("mul_after_flush", expected_lat(MUL, 32'd456));

    // Asynchronous reset in the middle of a divide.
    @(posedge clk); #1;
    valid_in = 1'b1; op = DIVU; rD1 = 32'd77; rD2 = 32'd5;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1; valid_in = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_C", C, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    no_done = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || stall !== 1'b0) no_done = 1'b0;
    end
    check("midrst_quiet", {31'd0, no_done}, 32'd1);

    run_op("mul_6_7", MUL, 32'd6, 32'd7, 32'd42);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
